// File: rtl/buffer_sequencer.sv
// Address/mode sequencer for the edge-map frame buffer: writes a frame in
// ascending order, then reads it back in descending order under out_ready.
module buffer_sequencer #(
  parameter int DEPTH  = 22500,
  parameter int ADDR_W = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              pix_valid,
  input  logic              out_ready,
  output logic [1:0]        mode,
  output logic [ADDR_W-1:0] cnt,
  output logic              out_valid,
  output logic              busy,
  output logic              frame_done,
  output logic              overrun
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_CAPTURE = 2'd1;
  localparam logic [1:0] S_DRAIN   = 2'd2;
  localparam logic [1:0] S_FLUSH   = 2'd3;

  localparam logic [1:0] MODE_RECEIVE = 2'b00;
  localparam logic [1:0] MODE_SEND    = 2'b01;
  localparam logic [1:0] MODE_HOLD    = 2'b10;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  logic [1:0]        state;
  logic [1:0]        state_nxt;
  logic [ADDR_W-1:0] cnt_nxt;
  logic              start_ok;
  logic              wr_fire;
  logic              rd_fire;
  logic              last_wr;
  logic              last_rd;
  logic              overrun_nxt;

  assign start_ok = (state == S_IDLE) && start;
  assign wr_fire  = (state == S_CAPTURE) && pix_valid;
  assign rd_fire  = (state == S_DRAIN) && out_ready;
  assign last_wr  = wr_fire && (cnt == LAST_ADDR);
  assign last_rd  = rd_fire && (cnt == '0);

  assign busy = (state == S_CAPTURE) || (state == S_DRAIN);

  // The buffer acts on every edge where mode is RECEIVE or SEND, so those
  // codes appear only in cycles where a transfer really happens.
  always_comb begin
    mode = MODE_HOLD;
    if (wr_fire) begin
      mode = MODE_RECEIVE;
    end else if (rd_fire) begin
      mode = MODE_SEND;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      S_IDLE: begin
        if (start) begin
          state_nxt = S_CAPTURE;
          cnt_nxt   = '0;
        end
      end
      S_CAPTURE: begin
        if (wr_fire) begin
          if (last_wr) begin
            state_nxt = S_DRAIN;
          end else begin
            cnt_nxt = cnt + ADDR_W'(1);
          end
        end
      end
      S_DRAIN: begin
        if (rd_fire) begin
          if (last_rd) begin
            state_nxt = S_FLUSH;
          end else begin
            cnt_nxt = cnt - ADDR_W'(1);
          end
        end
      end
      S_FLUSH: begin
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  // An accepted start clears the sticky flag, but a pixel arriving in the
  // same cycle is still outside CAPTURE and re-arms it.
  always_comb begin
    if (start_ok) begin
      overrun_nxt = pix_valid;
    end else begin
      overrun_nxt = overrun | (pix_valid && (state != S_CAPTURE));
    end
  end

  // out_valid trails the SEND issue by the buffer's one-cycle read latency;
  // frame_done lands with the final pixel.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      cnt        <= '0;
      out_valid  <= 1'b0;
      frame_done <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      out_valid  <= rd_fire;
      frame_done <= last_rd;
      overrun    <= overrun_nxt;
    end
  end

endmodule

// File: doc/buffer_sequencer.md
Name: buffer_sequencer

Overview:
Controller for the edge-map frame buffer. It generates the 15-bit address and the 2-bit mode for the buffer: sequential write order while edge-detector pixels arrive, then reverse-order readout toward the OR/combine stage. It sits between the edge-detection output, the frame buffer and the downstream consumer. It also provides a ready-gated read handshake and frame-level status.

Parameters:
DEPTH, 22500, pixels per frame (150x150)
ADDR_W, 15, address/counter width; DEPTH-1 must fit

Ports:
clk  in  1  system clock, all state on rising edge
reset  in  1  asynchronous, active-high; clears all state
start  in  1  one-cycle request to capture a new frame; honoured only in IDLE
pix_valid  in  1  edge detector presents a pixel to the buffer this cycle
out_ready  in  1  downstream will accept a pixel in the next cycle
mode  out  2  buffer mode: 2'b00 RECEIVE (write at cnt), 2'b01 SEND (read at cnt), 2'b10 HOLD (no buffer action)
cnt  out  ADDR_W  buffer address, registered
out_valid  out  1  buffer output bit is valid this cycle, registered
busy  out  1  high in CAPTURE or DRAIN
frame_done  out  1  one-cycle pulse when the last pixel is delivered
overrun  out  1  sticky: pix_valid seen outside CAPTURE; cleared on an accepted start

Behaviour:
- Reset (async, any time, including mid-frame): state=IDLE, cnt=0, out_valid=0, frame_done=0, overrun=0. Mode decodes to HOLD. Frame contents are abandoned.
- mode is combinational from state and inputs. It is never 00 or 01 unless a write or read actually happens that cycle, because the buffer acts on every edge where mode is 00 or 01.
- States:
  - IDLE:
    - mode=HOLD.
    - start=1 -> CAPTURE, cnt<=0, overrun<=0.
  - CAPTURE:
    - mode=00 iff pix_valid, else HOLD.
    - On pix_valid: the buffer writes at the current cnt, and cnt<=cnt+1.
    - On pix_valid with cnt==DEPTH-1: cnt<=DEPTH-1, state -> DRAIN. This write is the last one.
    - Gaps in pix_valid stall capture indefinitely.
  - DRAIN:
    - mode=01 iff out_ready, else HOLD.
    - On out_ready: out_valid<=1 next cycle (one-cycle buffer read latency); otherwise out_valid<=0.
    - On out_ready with cnt>0: cnt<=cnt-1.
    - On out_ready with cnt==0: state -> FLUSH, cnt held at 0.
    - Read order is DEPTH-1 down to 0.
  - FLUSH:
    - mode=HOLD.
    - out_valid=1 for the final pixel.
    - frame_done=1 this cycle only.
    - Next state is IDLE.
- busy = (state==CAPTURE)||(state==DRAIN).
- Handshake contract: out_ready high at edge N guarantees the consumer samples the buffer output at edge N+1. There is no back-pressure on the capture side.
- overrun: set on any cycle with pix_valid=1 while state != CAPTURE. Such a pixel is discarded (mode stays HOLD/SEND as above). It stays set until the next accepted start or reset.
- start outside IDLE is ignored and does not change overrun.
- Simultaneous events:
  - start and pix_valid in IDLE: start is accepted; the pixel is not written and sets overrun after the clear. Net result is overrun=1.
  - Last write and out_ready in the same cycle: the out_ready is ignored; the read begins in DRAIN.
- Arithmetic: cnt is unsigned ADDR_W bits and never wraps; the end conditions above bound it to 0..DEPTH-1.
- Latency: frame_done occurs exactly 1 cycle after the last SEND issue. Minimum frame time is 2*DEPTH+2 cycles from start.

Test Plan:
- DEPTH=4: start, then pix_valid for 4 consecutive cycles -> mode=00 with cnt 0,1,2,3; state DRAIN next cycle with cnt=3, busy=1.
- DEPTH=4: out_ready held high in DRAIN -> mode=01 with cnt 3,2,1,0; out_valid high for 4 cycles, each one cycle later; frame_done one pulse aligned with the 4th out_valid; then IDLE, busy=0.
- DEPTH=4: alternate out_ready 1/0 -> out_valid mirrors out_ready delayed by one cycle; mode=HOLD on ready-low cycles; cnt is held during stalls.
- pix_valid asserted in IDLE and again in DRAIN -> no mode=00 cycle, overrun=1, frame data unchanged. Next start clears overrun to 0.
- Reset asserted asynchronously mid-CAPTURE at cnt=2 -> immediately state IDLE, cnt=0, mode=HOLD, out_valid=0. A new start restarts at cnt=0.
- DEPTH=22500: full frame, continuous pix_valid and out_ready -> final write at cnt=22499, first read at 22499, last read at 0, frame_done at cycle 45001 after start.
